// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the multiplexed seven-segment
//               display driver.
//               Segment patterns are active-high, ordered {a,b,c,d,e,f,g} with
//               segment a in the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_pattern_t;

  // Shadowed state of the digit currently being scanned.
  typedef struct packed {
    nibble_t nib;
    logic    dp;
    logic    dark;
  } digit_view_t;

  localparam seg_pattern_t SEG_OFF   = 7'h00;

  localparam seg_pattern_t SEG_HEX_0 = 7'h7E;
  localparam seg_pattern_t SEG_HEX_1 = 7'h30;
  localparam seg_pattern_t SEG_HEX_2 = 7'h6D;
  localparam seg_pattern_t SEG_HEX_3 = 7'h79;
  localparam seg_pattern_t SEG_HEX_4 = 7'h33;
  localparam seg_pattern_t SEG_HEX_5 = 7'h5B;
  localparam seg_pattern_t SEG_HEX_6 = 7'h5F;
  localparam seg_pattern_t SEG_HEX_7 = 7'h70;
  localparam seg_pattern_t SEG_HEX_8 = 7'h7F;
  localparam seg_pattern_t SEG_HEX_9 = 7'h7B;
  localparam seg_pattern_t SEG_HEX_A = 7'h77;
  localparam seg_pattern_t SEG_HEX_B = 7'h1F;
  localparam seg_pattern_t SEG_HEX_C = 7'h4E;
  localparam seg_pattern_t SEG_HEX_D = 7'h3D;
  localparam seg_pattern_t SEG_HEX_E = 7'h4F;
  localparam seg_pattern_t SEG_HEX_F = 7'h47;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg
// Description : Combinational hex nibble to seven-segment decoder.
// Ports       : nib  - 4-bit hex value
//               seg  - 7-bit active-high pattern {a,b,c,d,e,f,g}
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule : hex7seg
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed seven-segment display scanner. Shadows the
//               display contents on load, steps through DIGITS digits with a
//               SCAN_DIV-clock slot each, and inserts a one-clock dark gap at
//               the start of every slot to avoid ghosting.
// Parameters  : DIGITS         - number of digits (1..8)
//               SCAN_DIV       - clocks per digit slot (>= 2)
//               SEL_ACTIVE_LOW - 1: selected digit drives its sel bit to 0
//               SEG_ACTIVE_LOW - 1: lit segment drives 0
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               data    - 4*DIGITS hex nibbles, nibble 0 is rightmost digit
//               dp      - per-digit decimal point request
//               blank   - per-digit force-dark request
//               load    - capture strobe for data/dp/blank
//               seg     - segments {a,b,c,d,e,f,g}
//               seg_dp  - decimal point segment
//               sel     - one-hot digit select (or all inactive)
// Options     : SEG_LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//               (other than digit 0) without a decimal point are darkened.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     sel
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Pin levels for "nothing lit / nothing selected".
  localparam logic [6:0]        SEG_IDLE   = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_IDLE   = {DIGITS{SEL_ACTIVE_LOW}};
  localparam logic              SEGDP_IDLE = SEG_ACTIVE_LOW;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [4*DIGITS-1:0] data_q,  data_d;
  logic [DIGITS-1:0]   dp_q,    dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [6:0]          seg_q,   seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   sel_q,   sel_d;

  // --------------------------------------------------------------------------
  // Prescaler, digit index and shadow registers
  // --------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    data_d  = data_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (load) begin
      data_d  = data;
      dp_d    = dp;
      blank_d = blank;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero suppression
  // --------------------------------------------------------------------------
  logic [DIGITS-1:0] lz_blank;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lz_upper_zero;

  // Walk from the most significant digit downwards; a digit is suppressed
  // while every nibble from it upwards is zero. Its own dp keeps it lit,
  // and digit 0 is always shown so a zero value still reads "0".
  always_comb begin
    lz_blank      = '0;
    lz_upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_upper_zero = lz_upper_zero & (data_q[4*i +: 4] == 4'h0);
      lz_blank[i]   = lz_upper_zero & ~dp_q[i];
    end
  end
`else
  assign lz_blank = '0;
`endif

  // --------------------------------------------------------------------------
  // Current digit selection
  // --------------------------------------------------------------------------
  digit_view_t       cur;
  logic [DIGITS-1:0] cur_onehot;

  always_comb begin
    cur        = '{nib: 4'h0, dp: 1'b0, dark: 1'b1};
    cur_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur.nib       = data_q[4*i +: 4];
        cur.dp        = dp_q[i];
        cur.dark      = blank_q[i] | lz_blank[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  logic [6:0] dec_seg;

  hex7seg u_hex7seg (
    .nib (cur.nib),
    .seg (dec_seg)
  );

  // --------------------------------------------------------------------------
  // Output staging
  // --------------------------------------------------------------------------
  // Prescaler value 0 is the first clock after an index advance (or after
  // reset); the pins are registered, so that clock appears as the dark gap
  // at the start of each slot on the pins.
  logic       slot_visible;
  logic [6:0] seg_hi;
  logic       dp_hi;
  logic [DIGITS-1:0] sel_hi;

  always_comb begin
    slot_visible = (presc_q != '0);
    seg_hi       = (slot_visible && !cur.dark) ? dec_seg : SEG_OFF;
    dp_hi        = slot_visible && !cur.dark && cur.dp;
    sel_hi       = slot_visible ? cur_onehot : '0;

    // Polarity is a pure inversion on the way to the pins.
    seg_d    = seg_hi ^ {7{SEG_ACTIVE_LOW}};
    seg_dp_d = dp_hi ^ SEG_ACTIVE_LOW;
    sel_d    = sel_hi ^ {DIGITS{SEL_ACTIVE_LOW}};
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      dp_q     <= '0;
      blank_q  <= '1;
      seg_q    <= SEG_IDLE;
      seg_dp_q <= SEGDP_IDLE;
      sel_q    <= SEL_IDLE;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      sel_q    <= sel_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign sel    = sel_q;

endmodule : seg_scan_driver
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (legal >= 2).
REQ-003 SHALL have parameter SEL_ACTIVE_LOW, default 1, where 1 means the selected digit drives sel bit 0.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 0, where 0 means a lit segment drives 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port data, input, 4*DIGITS bits: hex nibbles; nibble i is digit i, and digit 0 is the rightmost digit.
REQ-008 SHALL have port dp, input, DIGITS bits: per-digit decimal point request.
REQ-009 SHALL have port blank, input, DIGITS bits: per-digit force-dark request.
REQ-010 SHALL have port load, input, 1 bit: capture strobe for data, dp and blank.
REQ-011 SHALL have port seg, output, 7 bits: segments ordered {a,b,c,d,e,f,g}, with a as the MSB.
REQ-012 SHALL have port seg_dp, output, 1 bit: decimal point segment.
REQ-013 SHALL have port sel, output, DIGITS bits: one-hot digit select, or all inactive.

Function
REQ-014 SHALL capture data, dp and blank into shadow registers on every rising edge where load=1; with load=0 the shadow registers hold.
REQ-015 SHALL run a prescaler counting 0..SCAN_DIV-1 that wraps to 0.
REQ-016 SHALL advance the digit index on the edge where prescaler=SCAN_DIV-1, wrapping from DIGITS-1 to 0.
REQ-017 SHALL register all outputs, with one clock latency from shadow register and index to the pins.
REQ-018 SHALL drive sel all inactive, seg off and seg_dp off for exactly one clock after each index advance (anti-ghost gap); the remaining SCAN_DIV-1 clocks of the slot show the digit.
REQ-019 SHALL decode all 16 nibble values to active-high patterns as follows: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-020 SHALL force seg off and seg_dp off when the shadow blank bit of the current digit is 1, while sel stays asserted for that digit.
REQ-021 SHALL make a load that lands mid-slot visible on the current digit's pins one clock after the capture edge, without restarting the prescaler.
REQ-022 SHALL apply SEG_ACTIVE_LOW and SEL_ACTIVE_LOW as an output inversion only, with no effect on timing.

Reset
REQ-023 SHALL, on an edge with rst=1, clear the prescaler and index to 0, clear shadow data and dp to 0, and set shadow blank to all ones.
REQ-024 SHALL, on an edge with rst=1, drive sel all inactive, seg off and seg_dp off.
REQ-025 SHALL give rst priority over load, and a reset asserted mid-scan SHALL restart scanning at digit 0 with the slot starting at prescaler 0.

Configuration
REQ-026 SHALL, with SEG_LEADING_ZERO_BLANK_EN defined, darken every digit i>0 whose shadow nibble and all higher nibbles are 0 and whose dp bit is 0; digit 0 is never auto-blanked.
REQ-027 SHALL, without SEG_LEADING_ZERO_BLANK_EN, display zeros normally as pattern 7E.

Structure
REQ-028 SHALL place the 16-entry segment pattern constants and the segment-off constant in shared package seg_pkg.
REQ-029 SHALL implement nibble decode as sub-module hex7seg (4-bit input, 7-bit active-high output), instantiated once on the muxed nibble.

Verification (DIGITS=4, SCAN_DIV=4, SEL_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0)
REQ-030 SHALL cover reset: rst=1 for 2 clocks -> sel=4'b1111, seg=7'h00, seg_dp=0, and the display stays dark with no load.
REQ-031 SHALL cover scan order: load data=16'h1A3F, dp=4'b0010, blank=0 -> slots show digit 0 sel=1110 seg=47, digit 1 sel=1101 seg=79 dp=1, digit 2 sel=1011 seg=77, digit 3 sel=0111 seg=30, each for 3 clocks after a 1-clock all-1111 gap, then wrap to digit 0.
REQ-032 SHALL cover mid-slot load: during digit 0's 2nd visible clock, load data nibble 0 = 8 -> seg=7F on the next clock, and the slot ends on schedule.
REQ-033 SHALL cover blank: blank=4'b0100 -> digit 2 slot has sel=1011 and seg=00.
REQ-034 SHALL cover leading-zero blanking: data=16'h0042 -> with SEG_LEADING_ZERO_BLANK_EN, digits 3 and 2 show seg=00; without it, they show seg=7E.
REQ-035 SHALL cover reset mid-scan: rst asserted in digit 2's slot -> next clock sel=1111; after release, digit 0 is shown first, with a full 3-clock visible slot.
